dm_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single data-memory port (we/addr/wd/rd) between
//  the core load/store unit (m0) and a secondary master (m1: loader/debug/DMA).

---
 rtl/dm_arb_pkg.sv | 20 ++
 rtl/dm_arb_if.sv | 29 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter slice.
package dm_arb_pkg;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

endpackage

// File: rtl/dm_arb_if.sv
// One requester's port onto the data-memory arbiter: request/ack handshake,
// access payload, lock hint and the returned read data / error flag.
interface dm_arb_if
  import dm_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          lock;
  logic          ack;
  logic [DW-1:0] rd;
  logic          err;

  modport master (
    output req, we, addr, wd, lock,
    input  ack, rd, err
  );

  modport slave (
    input  req, we, addr, wd, lock,
    output ack, rd, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way pick for the data-memory arbiter. A locked owner that
// is still under its hold limit and still requesting keeps the port; otherwise
// a single requester wins outright and a tie goes to the master that was not
// served last.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic   req0_i,
  input  logic   req1_i,
  input  owner_e last_i,
  input  owner_e owner_i,
  input  logic   lock_i,
  input  logic   holdOk_i,
  output logic   valid_o,
  output owner_e winner_o,
  output logic   locked_o
);

  logic ownerReq;

  // Winner selection: lock extension first, then round-robin.
  always_comb begin
    ownerReq = (owner_i == OWNER_M0) ? req0_i : req1_i;
    valid_o  = req0_i | req1_i;
    winner_o = owner_i;
    locked_o = 1'b0;
    if (lock_i && holdOk_i && ownerReq) begin
      winner_o = owner_i;
      locked_o = 1'b1;
    end else if (req0_i && req1_i) begin
      winner_o = (last_i == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    end else if (req0_i) begin
      winner_o = OWNER_M0;
    end else if (req1_i) begin
      winner_o = OWNER_M1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single data-memory port. m0 is the core
// load/store unit, m1 a secondary master. Each access runs IDLE -> ACCESS ->
// RESP, so a request is acked two cycles after it is first seen.
// Optional feature macro: DM_ARB_RANGE_CHK_EN (addresses >= DEPTH are refused
// with an error ack instead of reaching the memory).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_arb_if.slave       m0,
  dm_arb_if.slave       m1,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wd,
  input  logic [DW-1:0] dm_rd
);

  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MaxHoldW = HW'(MAX_HOLD);
  localparam logic [AW:0]   DepthW   = (AW + 1)'(DEPTH);
`ifdef DM_ARB_RANGE_CHK_EN
  localparam logic RangeChkEn = 1'b1;
`else
  localparam logic RangeChkEn = 1'b0;
`endif

  state_e        state_q;
  owner_e        owner_q;
  owner_e        last_q;
  logic [HW-1:0] holdCnt_q;
  logic          ack0_q, ack1_q;
  logic          err0_q, err1_q;
  logic [DW-1:0] rd0_q, rd1_q;

  logic          ownReq, ownWe, ownLock;
  logic [AW-1:0] ownAddr;
  logic [DW-1:0] ownWd;
  logic          rangeErr;
  logic          holdOk;
  logic          pickValid, pickLocked;
  owner_e        pickWinner;

  // Route the current owner's request fields onto shared internal nets.
  always_comb begin
    if (owner_q == OWNER_M0) begin
      ownReq  = m0.req;
      ownWe   = m0.we;
      ownAddr = m0.addr;
      ownWd   = m0.wd;
      ownLock = m0.lock;
    end else begin
      ownReq  = m1.req;
      ownWe   = m1.we;
      ownAddr = m1.addr;
      ownWd   = m1.wd;
      ownLock = m1.lock;
    end
  end

  // Out-of-range detection only matters when the range check is built in.
  assign rangeErr = RangeChkEn & ({1'b0, ownAddr} >= DepthW);
  assign holdOk   = (holdCnt_q < MaxHoldW);

  rr_arb2 u_pick (
    .req0_i   (m0.req),
    .req1_i   (m1.req),
    .last_i   (last_q),
    .owner_i  (owner_q),
    .lock_i   (ownLock),
    .holdOk_i (holdOk),
    .valid_o  (pickValid),
    .winner_o (pickWinner),
    .locked_o (pickLocked)
  );

  // Memory port is driven only during ACCESS so reset drops it immediately.
  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_wd   = '0;
    if (state_q == ACCESS) begin
      dm_addr = ownAddr;
      dm_wd   = ownWd;
      dm_we   = ownWe & ownReq & ~rangeErr;
    end
  end

  // Arbitration FSM with registered ack, read data and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_M0;
      last_q    <= OWNER_M1;
      holdCnt_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            owner_q   <= pickWinner;
            holdCnt_q <= pickLocked ? holdCnt_q + 1'b1 : '0;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!ownReq) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
            if (owner_q == OWNER_M0) begin
              ack0_q <= 1'b1;
              err0_q <= rangeErr;
              rd0_q  <= rangeErr ? '0 : dm_rd;
            end else begin
              ack1_q <= 1'b1;
              err1_q <= rangeErr;
              rd1_q  <= rangeErr ? '0 : dm_rd;
            end
          end
        end
        RESP: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0.ack = ack0_q;
  assign m0.err = err0_q;
  assign m0.rd  = rd0_q;
  assign m1.ack = ack1_q;
  assign m1.err = err1_q;
  assign m1.rd  = rd1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, lock hold limit, reset during
// an access and a request dropped mid-access.
`timescale 1ns/1ps
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wd;
  logic [DW-1:0] dm_rd;
  logic [DW-1:0] ram [0:63];
  logic          ramInit;

  int testsRun    = 0;
  int testsFailed = 0;

  dm_arb_if #(.AW(AW), .DW(DW)) m0_if ();
  dm_arb_if #(.AW(AW), .DW(DW)) m1_if ();

  dm_arbiter #(.AW(AW), .DW(DW), .DEPTH(32), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .dm_we   (dm_we),
    .dm_addr (dm_addr),
    .dm_wd   (dm_wd),
    .dm_rd   (dm_rd)
  );

  always #5 clk = ~clk;

  assign dm_rd = ram[dm_addr[5:0]];

  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA500_0000 | i;
    end else if (dm_we) begin
      ram[dm_addr[5:0]] <= dm_wd;
    end
  end

  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] expRd;
    logic          expErr;
    int            expWe;
  } vec_t;

  vec_t vecs [9];
  int   expA [8];
  int   expB [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wd, input logic lock);
    if (m == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wd = wd; m0_if.lock = lock;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wd = wd; m1_if.lock = lock;
    end
  endtask

  function automatic logic getAck(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  function automatic logic [DW-1:0] getRd(input int m);
    return (m == 0) ? m0_if.rd : m1_if.rd;
  endfunction

  function automatic logic getErr(input int m);
    return (m == 0) ? m0_if.err : m1_if.err;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic runTxn(input int idx, input vec_t v);
    int            cyc, weCnt, otherAck;
    bit            got;
    logic [AW-1:0] addrSeen;
    cyc = 0; weCnt = 0; otherAck = 0; got = 0; addrSeen = '0;
    @(negedge clk);
    applyStimulus(v.m, 1'b1, v.we, v.addr, v.wd, 1'b0);
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) addrSeen = dm_addr;
      if (dm_we) weCnt++;
      if (getAck(1 - v.m)) otherAck++;
      if (getAck(v.m)) got = 1;
    end
    checkOutput($sformatf("v%0d_latency", idx), cyc, 2);
    checkOutput($sformatf("v%0d_addr", idx), addrSeen, v.addr);
    checkOutput($sformatf("v%0d_rd", idx), getRd(v.m), v.expRd);
    checkOutput($sformatf("v%0d_err", idx), getErr(v.m), v.expErr);
    applyStimulus(v.m, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput($sformatf("v%0d_we_cycles", idx), weCnt, v.expWe);
    checkOutput($sformatf("v%0d_other_ack", idx), otherAck, 0);
  endtask

  task automatic runOrder(input string tag, input int n0, input int n1, input logic lock1,
                          input int expOrder [8], input int nExp);
    int got [$];
    int rem0, rem1, cyc, both;
    rem0 = n0; rem1 = n1; cyc = 0; both = 0;
    @(negedge clk);
    applyStimulus(0, n0 > 0, 1'b0, 16'd1, '0, 1'b0);
    applyStimulus(1, n1 > 0, 1'b0, 16'd2, '0, lock1);
    while ((rem0 > 0 || rem1 > 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m0_if.ack && m1_if.ack) both++;
      if (m0_if.ack) begin
        got.push_back(0);
        rem0--;
        if (rem0 <= 0) applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
      end
      if (m1_if.ack) begin
        got.push_back(1);
        rem1--;
        if (rem1 <= 0) applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
      end
    end
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput({tag, "_grant_count"}, got.size(), nExp);
    for (int i = 0; i < nExp; i++) begin
      checkOutput($sformatf("%s_grant%0d", tag, i), (i < got.size()) ? got[i] : -1, expOrder[i]);
    end
    checkOutput({tag, "_dual_ack"}, both, 0);
  endtask

  initial begin
    int cyc, weCnt, ack0Cnt;
    bit got;

    rst_n   = 1'b0;
    ramInit = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);

    vecs[0] = '{0, 1'b1, 16'd5,  32'hDEAD_BEEF, 32'hA500_0005, 1'b0, 1};
    vecs[1] = '{0, 1'b0, 16'd5,  32'h0,         32'hDEAD_BEEF, 1'b0, 0};
    vecs[2] = '{1, 1'b1, 16'd3,  32'h0BAD_F00D, 32'hA500_0003, 1'b0, 1};
    vecs[3] = '{1, 1'b0, 16'd3,  32'h0,         32'h0BAD_F00D, 1'b0, 0};
    vecs[4] = '{0, 1'b0, 16'd0,  32'h0,         32'hA500_0000, 1'b0, 0};
    vecs[5] = '{1, 1'b0, 16'd31, 32'h0,         32'hA500_001F, 1'b0, 0};
`ifdef DM_ARB_RANGE_CHK_EN
    vecs[6] = '{0, 1'b1, 16'd40, 32'h55AA_55AA, 32'h0,         1'b1, 0};
    vecs[7] = '{0, 1'b0, 16'd40, 32'h0,         32'h0,         1'b1, 0};
    vecs[8] = '{1, 1'b1, 16'd32, 32'h1234_5678, 32'h0,         1'b1, 0};
`else
    vecs[6] = '{0, 1'b1, 16'd40, 32'h55AA_55AA, 32'hA500_0028, 1'b0, 1};
    vecs[7] = '{0, 1'b0, 16'd40, 32'h0,         32'h55AA_55AA, 1'b0, 0};
    vecs[8] = '{1, 1'b1, 16'd32, 32'h1234_5678, 32'hA500_0020, 1'b0, 1};
`endif
    expA = '{0, 1, 0, 1, 0, 1, 0, 0};
    expB = '{0, 1, 1, 1, 1, 1, 0, 1};

    @(posedge clk);
    #1 ramInit = 1'b0;
    doReset();

    checkOutput("rst_dm_we",   dm_we,     0);
    checkOutput("rst_dm_addr", dm_addr,   0);
    checkOutput("rst_dm_wd",   dm_wd,     0);
    checkOutput("rst_m0_ack",  m0_if.ack, 0);
    checkOutput("rst_m1_ack",  m1_if.ack, 0);
    checkOutput("rst_m0_rd",   m0_if.rd,  0);
    checkOutput("rst_m1_rd",   m1_if.rd,  0);
    checkOutput("rst_m0_err",  m0_if.err, 0);
    checkOutput("rst_m1_err",  m1_if.err, 0);

    for (int i = 0; i < 9; i++) runTxn(i, vecs[i]);
    checkOutput("m0_rd_hold", m0_if.rd, vecs[7].expRd);

    // Reset asserted while a write to address 7 sits in ACCESS.
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 16'd7, 32'h0000_1234, 1'b0);
    @(negedge clk);
    checkOutput("rstmid_we_before", dm_we, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_dm_we",   dm_we,     0);
    checkOutput("rstmid_dm_addr", dm_addr,   0);
    checkOutput("rstmid_dm_wd",   dm_wd,     0);
    checkOutput("rstmid_m0_ack",  m0_if.ack, 0);
    checkOutput("rstmid_m0_rd",   m0_if.rd,  0);
    checkOutput("rstmid_m1_rd",   m1_if.rd,  0);
    checkOutput("rstmid_m0_err",  m0_if.err, 0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack0Cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (m0_if.ack || m1_if.ack) ack0Cnt++;
    end
    checkOutput("rstmid_no_ack", ack0Cnt, 0);
    checkOutput("rstmid_ram7",   ram[7],  32'hA500_0007);

    // m0 wins the tie, then withdraws its request while in ACCESS.
    doReset();
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 16'd9, 32'hCAFE_0009, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'd4, '0, 1'b0);
    @(posedge clk);
    #1 applyStimulus(0, 1'b0, 1'b0, '0, '0, 1'b0);
    cyc = 0; weCnt = 0; ack0Cnt = 0; got = 0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (dm_we) weCnt++;
      if (m0_if.ack) ack0Cnt++;
      if (m1_if.ack) got = 1;
    end
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("drop_m1_ack_cycle", cyc,       4);
    checkOutput("drop_we_cycles",    weCnt,     0);
    checkOutput("drop_m0_ack",       ack0Cnt,   0);
    checkOutput("drop_m1_rd",        m1_if.rd,  32'hA500_0004);
    checkOutput("drop_ram9",         ram[9],    32'hA500_0009);
    repeat (2) @(negedge clk);

    doReset();
    runOrder("rr", 3, 3, 1'b0, expA, 6);
    doReset();
    runOrder("lock", 2, 6, 1'b1, expB, 8);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
